moore_seq_101: RTL and testbench
================================

// Module: moore_seq_101
// PURPOSE
//  - Moore FSM detecting serial bit pattern "101" on a 1-bit input stream, sampled one bit per clock.
//  - Output depends only on current state: asserted while FSM sits in the "101 seen" state.
//  - Leaf control block; feeds pattern-match flag to downstream logic; no handshake.
// PARAMETERS
//  - OVERLAP  default 1  1: trailing '1' of a match reused as start of next match; 0: non-overlapping
// PORTS
//  - clk_i      input  1  clock, all state on rising edge
//  - rst_i      input  1  reset, synchronous, active-high
//  - data_i     input  1  serial data bit, sampled every rising edge
//  - seq_det_o  output 1  high for each cycle FSM is in S_101
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - rst_i=1 at rising edge: state<=S_IDLE, overrides data_i; seq_det_o=0 from that edge on.
//  - Before first reset edge state/output undefined; bench must reset first.
//  - States, 2-bit encoding:
//      S_IDLE=2'd0 (nothing), S_1=2'd1 ("1"), S_10=2'd2 ("10"), S_101=2'd3 ("101").
//  - Transitions at rising edge, on sampled data_i:
//      S_IDLE: 1->S_1,   0->S_IDLE
//      S_1   : 1->S_1,   0->S_10
//      S_10  : 1->S_101, 0->S_IDLE
//      S_101 : 1->S_1
//              0->S_10 if OVERLAP=1, else 0->S_IDLE
//  - Output: seq_det_o = (state==S_101); pure decode of state register, no data_i path.
//  - Latency: seq_det_o rises on the edge that samples the final '1'.
//      Stays high exactly one cycle; a new "01" cannot complete sooner.
//  - Consecutive matches ("10101", OVERLAP=1): pulses separated by one low cycle.
//  - Reset while in S_101: seq_det_o falls at that edge; detection restarts from S_IDLE.
//  - Unused/illegal encodings: none (2 bits, 4 states); default branch -> S_IDLE.
//  - Reset has priority over all transitions; no X propagation from data_i into state after reset.
// STRUCTURE
//  - Package moore_seq_101_pkg:
//      typedef enum logic [1:0] state_e {S_IDLE, S_1, S_10, S_101}
//      localparam STATE_W=2
//  - Single module: state register (always_ff), next-state logic (always_comb), output decode.
//  - No sub-module.
// TESTING
//  - Reset: rst_i=1 one edge, data_i=0
//      -> seq_det_o=0, state S_IDLE.
//  - Basic: data_i 1,0,1 on successive edges
//      -> seq_det_o=1 for exactly the cycle after 3rd edge, then 0 when next bit is sampled.
//  - Overlap (OVERLAP=1): 1,0,1,0,1
//      -> seq_det_o pulses after edge 3 and edge 5; low after edge 4.
//  - Leading ones: 1,1,0,1
//      -> single pulse after edge 4; none before.
//  - Near miss: 1,0,0,1 and 0,0,0,0
//      -> seq_det_o never asserts.
//  - OVERLAP=0: 1,0,1,0,1 -> single pulse after edge 3.
//      Mid-match reset: 1,0,1 then rst_i=1 -> seq_det_o=0 at reset edge.
//  - Plus 15+ random bits compared against a 3-bit shift-register reference model.

Source files
------------

// File: rtl/moore_seq_101_pkg.sv
// -----------------------------------------------------------------------------
// moore_seq_101_pkg
// Shared definitions for the "101" serial pattern detector.
//   STATE_W : width of the detector state register
//   state_e : detector states, encoded 0..3 in the order the pattern is built
// -----------------------------------------------------------------------------
package moore_seq_101_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,   // no useful prefix seen
      S_1    = 2'd1,   // "1" seen
      S_10   = 2'd2,   // "10" seen
      S_101  = 2'd3    // full "101" seen, match flag high
   } state_e;

endpackage : moore_seq_101_pkg

// File: rtl/moore_seq_101.sv
// -----------------------------------------------------------------------------
// moore_seq_101
// Moore FSM that flags the serial bit pattern "101" on a 1-bit stream sampled
// once per rising clock edge. The flag depends only on the FSM state.
//
// Parameters
//   OVERLAP   : 1 -> the trailing '1' of a match may start the next match
//               0 -> matches never share bits
// Ports
//   clk_i     : clock, all state updates on the rising edge
//   rst_i     : synchronous active-high reset, returns the FSM to S_IDLE
//   data_i    : serial data bit, sampled every rising edge
//   seq_det_o : high for each cycle the FSM sits in S_101
// -----------------------------------------------------------------------------
module moore_seq_101
   import moore_seq_101_pkg::*;
#(
   parameter bit OVERLAP = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic data_i,
   output logic seq_det_o
);

   state_e state_r;
   state_e state_next_s;
   logic   seq_det_r;

   // Next-state decode for the pattern walk; S_101 exit depends on OVERLAP.
   always_comb begin
      state_next_s = S_IDLE;
      case (state_r)
         S_IDLE: begin
            if (data_i == 1'b1) begin
               state_next_s = S_1;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_1: begin
            if (data_i == 1'b1) begin
               state_next_s = S_1;
            end else begin
               state_next_s = S_10;
            end
         end
         S_10: begin
            if (data_i == 1'b1) begin
               state_next_s = S_101;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_101: begin
            if (data_i == 1'b1) begin
               state_next_s = S_1;
            end else if (OVERLAP) begin
               // the final '1' of the match doubles as the lead '1' of "10"
               state_next_s = S_10;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // State register and match flag; reset overrides any sampled data.
   // The flag flop is loaded with the decode of the incoming state, so it
   // always equals (state_r == S_101) while driving the output from a flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= S_IDLE;
         seq_det_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         seq_det_r <= (state_next_s == S_101);
      end
   end

   assign seq_det_o = seq_det_r;

endmodule : moore_seq_101

// File: tb/tb_moore_seq_101.sv
// -----------------------------------------------------------------------------
// tb_moore_seq_101
// Drives one bit stream into two detectors (OVERLAP=1 and OVERLAP=0) and
// compares their flags against a shift-register reference held in queues.
// -----------------------------------------------------------------------------
module tb_moore_seq_101;

   logic clk_i;
   logic rst_i;
   logic data_i;
   logic det_ov;
   logic det_no;

   int   n_checks;
   int   n_fail;
   int   pulses_ov;
   int   pulses_no;

   logic       exp_ov_q[$];
   logic       exp_no_q[$];

   logic [2:0] hist_ov;
   logic [2:0] hist_no;
   int         cnt_ov;
   int         cnt_no;

   moore_seq_101 #(.OVERLAP(1'b1)) dut_ov (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .data_i    (data_i),
      .seq_det_o (det_ov)
   );

   moore_seq_101 #(.OVERLAP(1'b0)) dut_no (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .data_i    (data_i),
      .seq_det_o (det_no)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference: last three bits since reset (or since the last match when
   // matches may not overlap); a match is three valid bits equal to 101.
   task automatic ref_step(input bit ovl, input logic r, input logic d,
                           inout logic [2:0] hist, inout int cnt, output logic det);
      if (r) begin
         hist = 3'b000;
         cnt  = 0;
         det  = 1'b0;
      end else begin
         hist = {hist[1:0], d};
         if (cnt < 3) cnt = cnt + 1;
         det = (cnt == 3) && (hist == 3'b101);
         if (det && !ovl) cnt = 0;
      end
   endtask

   // Drive one cycle of stimulus, queue the expectations, wait to sample point.
   task automatic drive_bit(input logic r, input logic d);
      logic e_ov;
      logic e_no;
      @(negedge clk_i);
      rst_i  = r;
      data_i = d;
      ref_step(1'b1, r, d, hist_ov, cnt_ov, e_ov);
      ref_step(1'b0, r, d, hist_no, cnt_no, e_no);
      exp_ov_q.push_back(e_ov);
      exp_no_q.push_back(e_no);
      @(posedge clk_i);
      #1;
      if (det_ov === 1'b1) pulses_ov++;
      if (det_no === 1'b1) pulses_no++;
   endtask

   task automatic test_reset();
      logic e;
      for (int i = 0; i < 2; i++) begin
         // second reset carries data_i=1 to show reset wins over data
         drive_bit(1'b1, (i == 1) ? 1'b1 : 1'b0);
         e = exp_ov_q.pop_front(); n_checks++;
         if (det_ov !== e) begin n_fail++; $display("FAIL reset[%0d] ovl=1: seq_det_o=%b expected %b", i, det_ov, e); end
         e = exp_no_q.pop_front(); n_checks++;
         if (det_no !== e) begin n_fail++; $display("FAIL reset[%0d] ovl=0: seq_det_o=%b expected %b", i, det_no, e); end
      end
      n_checks++;
      if (dut_ov.state_r !== 2'd0) begin n_fail++; $display("FAIL reset_state ovl=1: state=%0d expected 0", dut_ov.state_r); end
      n_checks++;
      if (dut_no.state_r !== 2'd0) begin n_fail++; $display("FAIL reset_state ovl=0: state=%0d expected 0", dut_no.state_r); end
   endtask

   task automatic test_basic();
      logic [3:0] pat;
      logic       e;
      pat = 4'b1010;
      pulses_ov = 0; pulses_no = 0;
      for (int i = 0; i <= 4; i++) begin
         if (i == 0) drive_bit(1'b1, 1'b0); else drive_bit(1'b0, pat[4-i]);
         e = exp_ov_q.pop_front(); n_checks++;
         if (det_ov !== e) begin n_fail++; $display("FAIL basic[%0d] ovl=1: seq_det_o=%b expected %b", i, det_ov, e); end
         e = exp_no_q.pop_front(); n_checks++;
         if (det_no !== e) begin n_fail++; $display("FAIL basic[%0d] ovl=0: seq_det_o=%b expected %b", i, det_no, e); end
      end
      n_checks++;
      if (pulses_ov != 1) begin n_fail++; $display("FAIL basic_pulses ovl=1: got %0d expected 1", pulses_ov); end
   endtask

   task automatic test_overlap();
      logic [4:0] pat;
      logic       e;
      pat = 5'b10101;
      pulses_ov = 0; pulses_no = 0;
      for (int i = 0; i <= 5; i++) begin
         if (i == 0) drive_bit(1'b1, 1'b0); else drive_bit(1'b0, pat[5-i]);
         e = exp_ov_q.pop_front(); n_checks++;
         if (det_ov !== e) begin n_fail++; $display("FAIL overlap[%0d] ovl=1: seq_det_o=%b expected %b", i, det_ov, e); end
         e = exp_no_q.pop_front(); n_checks++;
         if (det_no !== e) begin n_fail++; $display("FAIL overlap[%0d] ovl=0: seq_det_o=%b expected %b", i, det_no, e); end
      end
      n_checks++;
      if (pulses_ov != 2) begin n_fail++; $display("FAIL overlap_pulses ovl=1: got %0d expected 2", pulses_ov); end
      n_checks++;
      if (pulses_no != 1) begin n_fail++; $display("FAIL overlap_pulses ovl=0: got %0d expected 1", pulses_no); end
   endtask

   task automatic test_leading_ones();
      logic [3:0] pat;
      logic       e;
      pat = 4'b1101;
      pulses_ov = 0; pulses_no = 0;
      for (int i = 0; i <= 4; i++) begin
         if (i == 0) drive_bit(1'b1, 1'b0); else drive_bit(1'b0, pat[4-i]);
         e = exp_ov_q.pop_front(); n_checks++;
         if (det_ov !== e) begin n_fail++; $display("FAIL lead1[%0d] ovl=1: seq_det_o=%b expected %b", i, det_ov, e); end
         e = exp_no_q.pop_front(); n_checks++;
         if (det_no !== e) begin n_fail++; $display("FAIL lead1[%0d] ovl=0: seq_det_o=%b expected %b", i, det_no, e); end
      end
      n_checks++;
      if (pulses_ov != 1) begin n_fail++; $display("FAIL lead1_pulses ovl=1: got %0d expected 1", pulses_ov); end
   endtask

   task automatic test_near_miss();
      logic [7:0] pat;
      logic       e;
      pat = 8'b1001_0000;
      pulses_ov = 0; pulses_no = 0;
      for (int i = 0; i <= 8; i++) begin
         if (i == 0) drive_bit(1'b1, 1'b0); else drive_bit(1'b0, pat[8-i]);
         e = exp_ov_q.pop_front(); n_checks++;
         if (det_ov !== e) begin n_fail++; $display("FAIL nearmiss[%0d] ovl=1: seq_det_o=%b expected %b", i, det_ov, e); end
         e = exp_no_q.pop_front(); n_checks++;
         if (det_no !== e) begin n_fail++; $display("FAIL nearmiss[%0d] ovl=0: seq_det_o=%b expected %b", i, det_no, e); end
      end
      n_checks++;
      if (pulses_ov + pulses_no != 0) begin n_fail++; $display("FAIL nearmiss_pulses: got %0d expected 0", pulses_ov + pulses_no); end
   endtask

   task automatic test_mid_reset();
      // step: 0=reset, 1..3 = "101", 4 = reset with data_i=1, 5..6 = "01"
      logic [6:0] rst_pat;
      logic [6:0] dat_pat;
      logic       e;
      rst_pat = 7'b1000100;
      dat_pat = 7'b0101101;
      for (int i = 0; i <= 6; i++) begin
         drive_bit(rst_pat[6-i], dat_pat[6-i]);
         e = exp_ov_q.pop_front(); n_checks++;
         if (det_ov !== e) begin n_fail++; $display("FAIL midreset[%0d] ovl=1: seq_det_o=%b expected %b", i, det_ov, e); end
         e = exp_no_q.pop_front(); n_checks++;
         if (det_no !== e) begin n_fail++; $display("FAIL midreset[%0d] ovl=0: seq_det_o=%b expected %b", i, det_no, e); end
         if (i == 4) begin
            n_checks++;
            if (dut_ov.state_r !== 2'd0) begin n_fail++; $display("FAIL midreset_state: state=%0d expected 0", dut_ov.state_r); end
         end
      end
   endtask

   task automatic test_random();
      logic e;
      logic r;
      drive_bit(1'b1, 1'b0);
      e = exp_ov_q.pop_front(); n_checks++;
      if (det_ov !== e) begin n_fail++; $display("FAIL random_rst ovl=1: seq_det_o=%b expected %b", det_ov, e); end
      e = exp_no_q.pop_front(); n_checks++;
      if (det_no !== e) begin n_fail++; $display("FAIL random_rst ovl=0: seq_det_o=%b expected %b", det_no, e); end
      for (int i = 0; i < 60; i++) begin
         r = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
         drive_bit(r, 1'($urandom_range(0, 1)));
         e = exp_ov_q.pop_front(); n_checks++;
         if (det_ov !== e) begin n_fail++; $display("FAIL random[%0d] ovl=1: seq_det_o=%b expected %b", i, det_ov, e); end
         e = exp_no_q.pop_front(); n_checks++;
         if (det_no !== e) begin n_fail++; $display("FAIL random[%0d] ovl=0: seq_det_o=%b expected %b", i, det_no, e); end
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      pulses_ov = 0;
      pulses_no = 0;
      hist_ov   = 3'b000;
      hist_no   = 3'b000;
      cnt_ov    = 0;
      cnt_no    = 0;
      rst_i     = 1'b1;
      data_i    = 1'b0;

      test_reset();
      test_basic();
      test_overlap();
      test_leading_ones();
      test_near_miss();
      test_mid_reset();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_moore_seq_101
